// File: rtl/ber_pkg.sv
// Shared state type, width helper and parameter defaults for the BER
// synchronisation counter and its window sub-block.
package ber_pkg;

  localparam int DEF_NBT_COUNT_BITS_ERR = 64;
  localparam int DEF_MAX_DELAY          = 511;
  localparam int DEF_SYNC_WINDOW        = 511;
  localparam int DEF_BER_OK_THRESH      = 0;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP,
    COUNT
  } berState_t;

  // Bits needed to hold any value in 0..maxVal, never fewer than one.
  function automatic int idxWidth(input int maxVal);
    return (maxVal < 1) ? 1 : $clog2(maxVal + 1);
  endfunction

endpackage

// File: rtl/ber_window_counter.sv
// Counts strobes and errors over SYNC_WINDOW bits; pulses done_o on the
// closing strobe together with that window's final error total.
module ber_window_counter
  import ber_pkg::*;
#(
  parameter int  SYNC_WINDOW = DEF_SYNC_WINDOW,
  localparam int CW          = idxWidth(SYNC_WINDOW)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clear_i,
  input  logic          valid_i,
  input  logic          err_i,
  output logic          done_o,
  output logic [CW-1:0] errTotal_o
);

  logic [CW-1:0] cntQ, cntD;
  logic [CW-1:0] errQ, errD;

  // errTotal_o already includes the current strobe so the closing bit counts.
  assign errTotal_o = errQ + CW'(err_i);
  assign done_o     = valid_i && !clear_i && (cntQ == CW'(SYNC_WINDOW - 1));

  always_comb begin
    cntD = cntQ;
    errD = errQ;
    if (clear_i || done_o) begin
      cntD = '0;
      errD = '0;
    end else if (valid_i) begin
      cntD = cntQ + CW'(1);
      errD = errTotal_o;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cntQ <= '0;
      errQ <= '0;
    end else begin
      cntQ <= cntD;
      errQ <= errD;
    end
  end

endmodule

// File: rtl/ber_sync_counter.sv
// Per-branch BER stage: sweeps reference delays, locks on the lowest-error
// one, then accumulates errors/bits. BER_EARLY_LOCK_EN locks on the first clean window.
module ber_sync_counter
  import ber_pkg::*;
#(
  parameter int  NBT_COUNT_BITS_ERR = DEF_NBT_COUNT_BITS_ERR,
  parameter int  MAX_DELAY          = DEF_MAX_DELAY,
  parameter int  SYNC_WINDOW        = DEF_SYNC_WINDOW,
  parameter int  BER_OK_THRESH      = DEF_BER_OK_THRESH,
  localparam int DW                 = idxWidth(MAX_DELAY),
  localparam int EW                 = idxWidth(SYNC_WINDOW),
  localparam int AW                 = NBT_COUNT_BITS_ERR
) (
  input  logic          clk,
  input  logic          i_reset,
  input  logic          i_enable,
  input  logic          i_valid,
  input  logic          i_ref_bit,
  input  logic          i_rx_bit,
  output logic [AW-1:0] o_accum_err,
  output logic [AW-1:0] o_accum_tot,
  output logic [DW-1:0] o_delay,
  output logic          o_sync_done,
  output logic          o_ber_ok
);

  localparam logic [31:0] OK_THRESH = BER_OK_THRESH;

  berState_t stateQ, stateD;

  logic [MAX_DELAY-1:0] lineQ;
  logic [MAX_DELAY:0]   lineView;
  logic [DW-1:0]        candQ, bestQ, delayQ;
  logic [EW-1:0]        minErrQ;
  logic [AW-1:0]        accErrQ, accTotQ;
  logic                 syncDoneQ, berOkQ;

  logic          startSweep, sweepValid, countValid, winClear, lockNow;
  logic          bitErr, better, lastCand, earlyHit;
  logic          winDone;
  logic [EW-1:0] winErrTotal;
  logic [DW-1:0] tapIdx;

  // Index 0 is the bit arriving now, so index d is the reference d strobes ago.
  assign lineView = {lineQ, i_ref_bit};
  assign tapIdx   = (stateQ == SWEEP) ? candQ : delayQ;
  assign bitErr   = i_rx_bit ^ lineView[tapIdx];
  assign better   = winErrTotal < minErrQ;
  assign lastCand = candQ == DW'(MAX_DELAY);

`ifdef BER_EARLY_LOCK_EN
  assign earlyHit = winErrTotal == '0;
`else
  assign earlyHit = 1'b0;
`endif

  ber_window_counter #(
    .SYNC_WINDOW(SYNC_WINDOW)
  ) u_window (
    .clk_i     (clk),
    .rst_i     (i_reset),
    .clear_i   (winClear),
    .valid_i   (sweepValid || countValid),
    .err_i     (bitErr),
    .done_o    (winDone),
    .errTotal_o(winErrTotal)
  );

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      stateQ <= IDLE;
    end else begin
      stateQ <= stateD;
    end
  end

  always_comb begin
    stateD = stateQ;
    if (!i_enable) begin
      stateD = IDLE;
    end else begin
      case (stateQ)
        IDLE:    stateD = SWEEP;
        SWEEP:   if (lockNow) stateD = COUNT;
        COUNT:   stateD = COUNT;
        default: stateD = IDLE;
      endcase
    end
  end

  // A strobe sampled with i_enable low is dropped, hence the enable gating.
  always_comb begin
    startSweep = 1'b0;
    sweepValid = 1'b0;
    countValid = 1'b0;
    winClear   = 1'b0;
    lockNow    = 1'b0;
    case (stateQ)
      IDLE: begin
        winClear   = 1'b1;
        startSweep = i_enable;
      end
      SWEEP: begin
        sweepValid = i_enable && i_valid;
        lockNow    = sweepValid && winDone && (lastCand || earlyHit);
      end
      COUNT:   countValid = i_enable && i_valid;
      default: winClear = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      lineQ <= '0;
    end else if (i_valid) begin
      lineQ <= lineView[MAX_DELAY-1:0];
    end
  end

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      candQ   <= '0;
      bestQ   <= '0;
      minErrQ <= '1;
    end else if (startSweep) begin
      candQ   <= '0;
      bestQ   <= '0;
      minErrQ <= '1;
    end else if (sweepValid && winDone) begin
      if (better) begin
        minErrQ <= winErrTotal;
        bestQ   <= candQ;
      end
      if (!lockNow) begin
        candQ <= candQ + DW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      delayQ    <= '0;
      syncDoneQ <= 1'b0;
      berOkQ    <= 1'b0;
    end else if (!i_enable) begin
      syncDoneQ <= 1'b0;
      berOkQ    <= 1'b0;
    end else if (lockNow) begin
      delayQ    <= better ? candQ : bestQ;
      syncDoneQ <= 1'b1;
    end else if (countValid && winDone) begin
      berOkQ <= 32'(winErrTotal) <= OK_THRESH;
    end
  end

  // Both totals stop together at saturation so their ratio stays meaningful.
  always_ff @(posedge clk or posedge i_reset) begin
    if (i_reset) begin
      accErrQ <= '0;
      accTotQ <= '0;
    end else if (startSweep) begin
      accErrQ <= '0;
      accTotQ <= '0;
    end else if (countValid && (accTotQ != '1)) begin
      accTotQ <= accTotQ + AW'(1);
      accErrQ <= accErrQ + AW'(bitErr);
    end
  end

  assign o_accum_err = accErrQ;
  assign o_accum_tot = accTotQ;
  assign o_delay     = delayQ;
  assign o_sync_done = syncDoneQ;
  assign o_ber_ok    = berOkQ;

endmodule

// File: tb/tb_ber_sync_counter.sv
// Directed bench for ber_sync_counter with a small expected-value scoreboard;
// lock timing follows BER_EARLY_LOCK_EN when it is defined.
module tb_ber_sync_counter;

  localparam int MAXD = 15;
  localparam int SW   = 32;
`ifdef BER_EARLY_LOCK_EN
  localparam int LOCK_PRBS = 8 * SW;
  localparam int LOCK_PER  = 4 * SW;
`else
  localparam int LOCK_PRBS = (MAXD + 1) * SW;
  localparam int LOCK_PER  = (MAXD + 1) * SW;
`endif

  localparam int SEL_SYNC   = 0;
  localparam int SEL_OK     = 1;
  localparam int SEL_DELAY  = 2;
  localparam int SEL_ERR    = 3;
  localparam int SEL_TOT    = 4;
  localparam int SEL_THR_OK = 5;
  localparam int SEL_SATERR = 6;
  localparam int SEL_SATTOT = 7;

  logic clk = 1'b0;
  logic i_reset, i_enable, i_valid, i_ref_bit, i_rx_bit, rxSat;

  logic [63:0] accErr, accTot, thrErr, thrTot;
  logic [3:0]  delay, thrDelay, satDelay;
  logic        syncDone, berOk, thrSync, thrOk, satSync, satOk;
  logic [7:0]  satErr, satTot;

  typedef struct {
    string       tag;
    int          sel;
    logic [63:0] exp;
  } exp_t;

  exp_t sb[$];
  bit   hist[$];
  int   testCount = 0;
  int   failCount = 0;
  logic [8:0] lfsr;
  logic [7:0] pat;
  int   refMode, patIdx, rxDelay;
  bit   satInvert;

  always #5 clk = ~clk;

  ber_sync_counter #(
    .NBT_COUNT_BITS_ERR(64), .MAX_DELAY(MAXD), .SYNC_WINDOW(SW), .BER_OK_THRESH(0)
  ) dut (
    .clk(clk), .i_reset(i_reset), .i_enable(i_enable), .i_valid(i_valid),
    .i_ref_bit(i_ref_bit), .i_rx_bit(i_rx_bit),
    .o_accum_err(accErr), .o_accum_tot(accTot), .o_delay(delay),
    .o_sync_done(syncDone), .o_ber_ok(berOk)
  );

  ber_sync_counter #(
    .NBT_COUNT_BITS_ERR(64), .MAX_DELAY(MAXD), .SYNC_WINDOW(SW), .BER_OK_THRESH(2)
  ) dutThr (
    .clk(clk), .i_reset(i_reset), .i_enable(i_enable), .i_valid(i_valid),
    .i_ref_bit(i_ref_bit), .i_rx_bit(i_rx_bit),
    .o_accum_err(thrErr), .o_accum_tot(thrTot), .o_delay(thrDelay),
    .o_sync_done(thrSync), .o_ber_ok(thrOk)
  );

  ber_sync_counter #(
    .NBT_COUNT_BITS_ERR(8), .MAX_DELAY(MAXD), .SYNC_WINDOW(SW), .BER_OK_THRESH(0)
  ) dutSat (
    .clk(clk), .i_reset(i_reset), .i_enable(i_enable), .i_valid(i_valid),
    .i_ref_bit(i_ref_bit), .i_rx_bit(rxSat),
    .o_accum_err(satErr), .o_accum_tot(satTot), .o_delay(satDelay),
    .o_sync_done(satSync), .o_ber_ok(satOk)
  );

  function automatic logic [63:0] observe(input int sel);
    case (sel)
      SEL_SYNC:   return 64'(syncDone);
      SEL_OK:     return 64'(berOk);
      SEL_DELAY:  return 64'(delay);
      SEL_ERR:    return accErr;
      SEL_TOT:    return accTot;
      SEL_THR_OK: return 64'(thrOk);
      SEL_SATERR: return 64'(satErr);
      SEL_SATTOT: return 64'(satTot);
      default:    return '1;
    endcase
  endfunction

  function automatic bit nextRef();
    bit b;
    if (refMode == 0) begin
      b    = lfsr[8] ^ lfsr[4];
      lfsr = {lfsr[7:0], b};
    end else begin
      b      = pat[patIdx];
      patIdx = (patIdx + 1) % 8;
    end
    return b;
  endfunction

  task automatic expectOut(input string tag, input int sel, input logic [63:0] exp);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic checkOutput();
    exp_t        e;
    logic [63:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.sel);
      testCount++;
      assert (obs === e.exp) else begin
        failCount++;
        $error("[TB] FAIL %s: observed %0d, expected %0d", e.tag, obs, e.exp);
      end
    end
  endtask

  // One valid strobe; rx is the reference delayed by rxDelay, optionally flipped.
  task automatic applyStimulus(input bit flip);
    bit r, clean;
    @(negedge clk);
    r = nextRef();
    hist.push_back(r);
    clean     = (hist.size() > rxDelay) ? hist[hist.size() - 1 - rxDelay] : 1'b0;
    i_ref_bit = r;
    i_rx_bit  = clean ^ flip;
    rxSat     = satInvert ? ~clean : clean;
    i_valid   = 1'b1;
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic runLock(input int expDelay, input int lockCount, input string label);
    for (int v = 0; v < lockCount; v++) begin
      applyStimulus(1'b0);
      if (v == lockCount - 2) begin
        expectOut({label, " sync_done before last window"}, SEL_SYNC, 64'd0);
        checkOutput();
      end
    end
    expectOut({label, " sync_done at lock"}, SEL_SYNC, 64'd1);
    expectOut({label, " locked delay"}, SEL_DELAY, 64'(expDelay));
    checkOutput();
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    i_reset   = 1'b1;
    i_enable  = 1'b0;
    i_valid   = 1'b0;
    i_ref_bit = 1'b0;
    i_rx_bit  = 1'b0;
    rxSat     = 1'b0;
    lfsr      = 9'h1FF;
    pat       = 8'b1011_0010;
    refMode   = 0;
    patIdx    = 0;
    rxDelay   = 7;
    satInvert = 1'b0;

    repeat (3) @(negedge clk);
    expectOut("reset sync_done", SEL_SYNC, 64'd0);
    expectOut("reset ber_ok", SEL_OK, 64'd0);
    expectOut("reset delay", SEL_DELAY, 64'd0);
    expectOut("reset accum_err", SEL_ERR, 64'd0);
    expectOut("reset accum_tot", SEL_TOT, 64'd0);
    checkOutput();
    i_reset = 1'b0;

    repeat (5) applyStimulus(1'b1);
    expectOut("idle ignores valid tot", SEL_TOT, 64'd0);
    expectOut("idle ignores valid err", SEL_ERR, 64'd0);
    expectOut("idle sync_done", SEL_SYNC, 64'd0);
    checkOutput();

    // Test 1: PRBS9 with rx delayed 7 bits.
    i_enable = 1'b1;
    @(negedge clk);
    runLock(7, LOCK_PRBS, "t1");
    satInvert = 1'b1;
    repeat (64) applyStimulus(1'b0);
    expectOut("t1 accum_tot", SEL_TOT, 64'd64);
    expectOut("t1 accum_err", SEL_ERR, 64'd0);
    expectOut("t1 ber_ok", SEL_OK, 64'd1);
    expectOut("t1 thr ber_ok", SEL_THR_OK, 64'd1);
    expectOut("t6 sat tot after 64", SEL_SATTOT, 64'd64);
    expectOut("t6 sat err after 64", SEL_SATERR, 64'd64);
    checkOutput();

    // Test 2: one flip every 16 bits gives two errors per window.
    for (int i = 0; i < 64; i++) begin
      applyStimulus((i % 16) == 0);
      if (i == 30) begin
        expectOut("t2 ber_ok before window closes", SEL_OK, 64'd1);
        checkOutput();
      end
    end
    expectOut("t2 ber_ok thresh0", SEL_OK, 64'd0);
    expectOut("t2 ber_ok thresh2", SEL_THR_OK, 64'd1);
    expectOut("t2 accum_err", SEL_ERR, 64'd4);
    expectOut("t2 accum_tot", SEL_TOT, 64'd128);
    checkOutput();

    // Test 6: 8-bit accumulators with every bit wrong after lock.
    repeat (127) applyStimulus(1'b0);
    expectOut("t6 sat tot at 255", SEL_SATTOT, 64'd255);
    expectOut("t6 sat err at 255", SEL_SATERR, 64'd255);
    checkOutput();
    repeat (33) applyStimulus(1'b0);
    expectOut("t6 sat tot frozen", SEL_SATTOT, 64'd255);
    expectOut("t6 sat err frozen", SEL_SATERR, 64'd255);
    checkOutput();

    // Test 3: period-8 reference, delays 3 and 11 both clean.
    i_enable = 1'b0;
    @(negedge clk);
    expectOut("t3 disable sync_done", SEL_SYNC, 64'd0);
    checkOutput();
    satInvert = 1'b0;
    refMode   = 1;
    patIdx    = 0;
    rxDelay   = 3;
    i_enable  = 1'b1;
    @(negedge clk);
    runLock(3, LOCK_PER, "t3");

    // Test 4: 5 errors in 200 bits, then disable on a valid strobe.
    for (int i = 0; i < 200; i++) begin
      applyStimulus(i == 5 || i == 40 || i == 70 || i == 100 || i == 130);
    end
    expectOut("t4 accum_err", SEL_ERR, 64'd5);
    expectOut("t4 accum_tot", SEL_TOT, 64'd200);
    expectOut("t4 ber_ok clean window", SEL_OK, 64'd1);
    checkOutput();
    i_enable = 1'b0;
    applyStimulus(1'b1);
    expectOut("t4 disabled sync_done", SEL_SYNC, 64'd0);
    expectOut("t4 disabled ber_ok", SEL_OK, 64'd0);
    expectOut("t4 hold accum_err", SEL_ERR, 64'd5);
    expectOut("t4 hold accum_tot", SEL_TOT, 64'd200);
    expectOut("t4 hold delay", SEL_DELAY, 64'd3);
    checkOutput();
    i_enable = 1'b1;
    @(negedge clk);
    expectOut("t4 reenable accum_err", SEL_ERR, 64'd0);
    expectOut("t4 reenable accum_tot", SEL_TOT, 64'd0);
    expectOut("t4 reenable sync_done", SEL_SYNC, 64'd0);
    expectOut("t4 reenable delay", SEL_DELAY, 64'd3);
    checkOutput();

    // Test 5: asynchronous reset in the middle of a sweep.
    repeat (40) applyStimulus(1'b0);
    @(posedge clk);
    #2;
    i_reset = 1'b1;
    #1;
    expectOut("t5 async reset delay", SEL_DELAY, 64'd0);
    expectOut("t5 async reset sync_done", SEL_SYNC, 64'd0);
    expectOut("t5 async reset ber_ok", SEL_OK, 64'd0);
    expectOut("t5 async reset accum_tot", SEL_TOT, 64'd0);
    checkOutput();
    @(negedge clk);
    @(negedge clk);
    hist.delete();
    lfsr    = 9'h1FF;
    refMode = 0;
    rxDelay = 7;
    i_reset = 1'b0;
    @(negedge clk);
    runLock(7, LOCK_PRBS, "t5");
    repeat (64) applyStimulus(1'b0);
    expectOut("t5 accum_tot", SEL_TOT, 64'd64);
    expectOut("t5 accum_err", SEL_ERR, 64'd0);
    expectOut("t5 ber_ok", SEL_OK, 64'd1);
    checkOutput();

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
